// File: rtl/mem_line_if.sv
// mem_line_if: cache-to-memory line transfer bus (request, writeback beats, refill beats)
interface mem_line_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        done;
    modport master (
        output req_valid, req_we, req_addr, wr_valid, wr_data,
        input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done
    );
    modport slave (
        input  req_valid, req_we, req_addr, wr_valid, wr_data,
        output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, done
    );
endinterface

// File: rtl/mem_line_responder.sv
// mem_line_responder: fixed-latency main-memory model serving whole-line refills and writebacks
module mem_line_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4,
    parameter int BURST_LEN  = 4
) (
    input logic       clk,
    input logic       rst_n,
    mem_line_if.slave bus
);
    localparam int BW = $clog2(BURST_LEN);
    localparam int LW = ADDR_WIDTH - BW;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
    typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [LW-1:0] line_q, line_d;
    logic          we_q, we_d;
    logic          req_ready_q, req_ready_d;
    logic          wr_ready_q, wr_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_last_q, rsp_last_d;
    logic          done_q, done_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [31:0]   mem [0:(1<<ADDR_WIDTH)-1];
    logic          last_beat;
    logic          wr_en;
    logic          unused_addr;
    assign last_beat   = beat_q == LAST;
    assign wr_en       = state_q == WR_BURST && bus.wr_valid;
    // Byte offset, in-line word offset and bits above the array alias away.
    assign unused_addr = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[BW+1:0]};
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        line_d  = line_q;
        we_d    = we_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = WAIT;
                lat_d   = CW'(LATENCY - 1);
                line_d  = bus.req_addr[ADDR_WIDTH+1:BW+2];
                we_d    = bus.req_we;
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == '0) begin
                    state_d = we_q ? WR_BURST : RD_BURST;
                    lat_d   = '0;
                    beat_d  = '0;
                end
            end
            RD_BURST: begin
                beat_d  = beat_q + 1'b1;
                state_d = last_beat ? DONE : RD_BURST;
            end
            WR_BURST: if (bus.wr_valid) begin
                beat_d  = beat_q + 1'b1;
                state_d = last_beat ? DONE : WR_BURST;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        req_ready_d = state_d == IDLE;
        wr_ready_d  = state_d == WR_BURST;
        rsp_valid_d = state_d == RD_BURST;
        rsp_last_d  = rsp_valid_d && beat_d == LAST;
        done_d      = state_d == DONE;
        rsp_data_d  = rsp_valid_d ? mem[{line_q, beat_d}] : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            we_q        <= 1'b0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            we_q        <= we_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            done_q      <= done_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
    // Backing store is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{line_q, beat_q}] <= bus.wr_data;
    end
    assign bus.req_ready = req_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: randomized scoreboard bench for mem_line_responder
module tb_mem_line_responder;
    localparam int AW = 10, LAT = 4, BL = 4, DEPTH = 1 << AW;
    logic clk = 0;
    logic rst_n = 1;
    int checks = 0, errors = 0, exp_done = 0, got_done = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [32:0] exp_q [$];
    mem_line_if bus();
    mem_line_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference addressing: word index modulo depth, line-aligned, beat offset added.
    function automatic int word_of(input logic [31:0] a, input int i);
        int w = int'(a >> 2) % DEPTH;
        return w - w % BL + i;
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.done) got_done++;
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got data %0h, expected no beat", bus.rsp_data);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_beat", {bus.rsp_last, bus.rsp_data}, e);
            end
        end else chk("rsp_idle", {bus.rsp_last, bus.rsp_data}, 0);
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", bus.req_ready, 1);
    endtask

    // mode 0: wr_valid held high, 1: random, 2: fixed 1,0,0,1,1,0,1 pattern
    task automatic do_write(input logic [31:0] a, input logic [BL-1:0][31:0] d, input int mode, input int abort_at);
        logic [6:0] pat = 7'b1001101;
        int k = 0, beats = 0, first = -1, idx = 0;
        logic v;
        wait_ready();
        bus.req_valid = 1; bus.req_we = 1; bus.req_addr = a;
        @(posedge clk); #1;
        bus.req_valid = 0; bus.req_addr = $urandom;
        while (beats < BL && k < 200) begin
            v = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) :
                (!bus.wr_ready || idx > 6) ? 1'b1 : pat[6-idx];
            bus.wr_valid = v;
            bus.wr_data = v ? d[beats] : $urandom;
            if (bus.wr_ready) begin
                if (first < 0) first = k;
                idx++;
                if (v) begin
                    ref_mem[word_of(a, beats)] = d[beats];
                    beats++;
                end
            end
            @(posedge clk); #1;
            k++;
            if (abort_at > 0 && beats == abort_at) begin
                bus.wr_valid = 0;
                rst_n = 0; #1;
                chk("abort_outputs", {bus.req_ready, bus.wr_ready, bus.rsp_valid, bus.rsp_last, bus.done}, 0);
                @(posedge clk); #1;
                chk("abort_held", {bus.req_ready, bus.wr_ready, bus.rsp_valid, bus.rsp_last, bus.done}, 0);
                rst_n = 1; #1;
                chk("abort_release_ready", bus.req_ready, 0);
                @(posedge clk); #1;
                chk("abort_ready_back", bus.req_ready, 1);
                return;
            end
        end
        bus.wr_valid = 0;
        chk("wr_first_ready", first, LAT);
        chk("wr_beats", beats, BL);
        chk("wr_done", bus.done, 1);
        exp_done++;
    endtask

    task automatic do_read(input logic [31:0] a, input bit busy);
        wait_ready();
        bus.req_valid = 1; bus.req_we = 0; bus.req_addr = a;
        @(posedge clk); #1;
        for (int i = 0; i < BL; i++) exp_q.push_back({i == BL - 1, ref_mem[word_of(a, i)]});
        for (int k = 0; k <= LAT + BL + 1; k++) begin
            bus.req_valid = busy && (k == 1 || k == LAT + 1);
            bus.req_we = 1'($urandom_range(0, 1));
            bus.req_addr = $urandom;
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_data = $urandom;
            chk("rd_timing", {bus.rsp_valid, bus.done, bus.req_ready, bus.wr_ready},
                {k >= LAT && k < LAT + BL, k == LAT + BL, k == LAT + BL + 1, 1'b0});
            if (k < LAT + BL + 1) begin
                @(posedge clk); #1;
            end
        end
        bus.req_valid = 0; bus.wr_valid = 0;
        exp_done++;
    endtask

    initial begin
        logic [BL-1:0][31:0] d;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.wr_valid = 0; bus.wr_data = 0;
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.req_ready, bus.wr_ready, bus.rsp_valid, bus.rsp_last, bus.done}, 0);
        rst_n = 1; #1;
        chk("reset_release_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("reset_ready", bus.req_ready, 1);
        for (int l = 0; l < DEPTH / BL; l++) begin
            for (int i = 0; i < BL; i++) d[i] = $urandom;
            do_write(32'(l * BL * 4), d, 0, 0);
        end
        d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        do_write(32'h40, d, 0, 0);
        do_read(32'h4C, 0);
        d = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
        do_write(32'h80, d, 2, 0);
        do_read(32'h80, 0);
        do_read(32'h40, 1);
        for (int i = 0; i < BL; i++) d[i] = $urandom;
        do_write(32'h1000, d, 1, 0);
        do_read(32'h0, 0);
        do_read(32'h41, 0);
        do_read(32'h43, 1);
        for (int i = 0; i < BL; i++) d[i] = $urandom;
        do_write(32'hC0, d, 0, 2);
        do_read(32'hC0, 0);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < BL; i++) d[i] = $urandom;
                do_write($urandom, d, int'($urandom_range(0, 1)), 0);
            end else do_read($urandom, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", got_done, exp_done);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
